btn_toggle_gen: RTL

Upstream stage for the T flip-flop. It takes a raw, bouncy, asynchronous push-button, synchronises and debounces it, and emits clean single-cycle toggle pulses on t_out for the flip-flop's t input. An optional auto-repeat feature produces additional pulses while the button is held. A pulse counter is provided for debug and verification.

---
 rtl/btn_toggle_gen.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/btn_toggle_gen.sv
// Push-button front end: synchronises and debounces a raw button and emits
// registered single-cycle toggle pulses, with optional auto-repeat while held.
module btn_toggle_gen #(
  parameter int DB_CYCLES     = 4,
  parameter int HOLD_CYCLES   = 0,
  parameter int REPEAT_CYCLES = 8,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_in,
  input  logic       enable,
  output logic       t_out,
  output logic       btn_state,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    PRESSED  = 2'd2,
    REL_DB   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
  localparam logic             DB_SINGLE = (DB_CYCLES == 1);
  localparam logic             REPEAT_ON = (HOLD_CYCLES > 0);

  logic             s1;
  logic             btn_s;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             rep;
  logic             rep_nxt;
  logic             pulse;
  logic             fire;

  // Two-flop synchroniser for the asynchronous button level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1    <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      s1    <= btn_in;
      btn_s <= s1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= CNT_ZERO;
      rep   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rep   <= rep_nxt;
    end
  end

  // rep marks that the first (HOLD-length) repeat has already fired
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rep_nxt   = rep;
    pulse     = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s) begin
          if (DB_SINGLE) begin
            state_nxt = PRESSED;
            cnt_nxt   = CNT_ZERO;
            rep_nxt   = 1'b0;
            pulse     = 1'b1;
          end else begin
            state_nxt = PRESS_DB;
            cnt_nxt   = CNT_ONE;
          end
        end
      end
      PRESS_DB: begin
        if (!btn_s) begin
          state_nxt = IDLE;
          cnt_nxt   = CNT_ZERO;
        end else if (cnt == DB_LAST) begin
          state_nxt = PRESSED;
          cnt_nxt   = CNT_ZERO;
          rep_nxt   = 1'b0;
          pulse     = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          if (DB_SINGLE) begin
            state_nxt = IDLE;
            cnt_nxt   = CNT_ZERO;
          end else begin
            state_nxt = REL_DB;
            cnt_nxt   = CNT_ONE;
          end
        end else if (REPEAT_ON) begin
          if (cnt == (rep ? REP_LAST : HOLD_LAST)) begin
            cnt_nxt = CNT_ZERO;
            rep_nxt = 1'b1;
            pulse   = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
      end
      REL_DB: begin
        if (btn_s) begin
          state_nxt = PRESSED;
          cnt_nxt   = CNT_ZERO;
          rep_nxt   = 1'b0;
        end else if (cnt == DB_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = CNT_ZERO;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = CNT_ZERO;
        rep_nxt   = 1'b0;
      end
    endcase
  end

  assign fire = pulse & enable;

  // Registered pulse output and wrapping pulse counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      t_out       <= 1'b0;
      press_count <= 8'd0;
    end else begin
      t_out <= fire;
      if (fire) begin
        press_count <= press_count + 8'd1;
      end
    end
  end

  assign btn_state = (state == PRESSED) || (state == REL_DB);

endmodule
